enc_dec_op_sequencer: RTL and testbench
=======================================

// Module: enc_dec_op_sequencer
// PURPOSE
//  Sequences one encoder/decoder operation after the CPU writes CTRL over APB.
//  Sits between the APB register file and the enc/noise/dec datapath.
//  Latches the configuration, fires each datapath stage in order, waits for its done,
//  then reports completion or error.
// PARAMETERS
//  AMBA_WORD       32   width of the CTRL/CODEWORD_WIDTH register inputs
//  TIMEOUT_CYCLES  64   maximum cycles to wait for a stage done (WATCHDOG_EN only)
// PORTS
//  clk            in   1          system clock, rising edge
//  rst            in   1          asynchronous reset, active-high
//  ctrl_wr        in   1          1-cycle pulse: APB write to CTRL completed
//  ctrl           in   AMBA_WORD  CTRL; [1:0] mode: 00 enc, 01 dec, 10 full channel, 11 illegal
//  codeword_width in   AMBA_WORD  [1:0]: 00=8b, 01=16b, 10=32b, 11 illegal
//  enc_done       in   1          encoder finished (level, sampled in ENC)
//  dec_done       in   1          decoder finished (level, sampled in DEC)
//  latch_en       out  1          1-cycle: datapath captures DATA_IN/NOISE
//  width_q        out  2          latched codeword width, stable for whole operation
//  enc_start      out  1          1-cycle encoder start
//  noise_en       out  1          1-cycle: XOR NOISE into codeword
//  dec_start      out  1          1-cycle decoder start
//  busy           out  1          high from LATCH through DONE inclusive
//  op_done        out  1          1-cycle completion pulse
//  op_error       out  1          sticky error; cleared by next accepted ctrl_wr
// BEHAVIOUR
//  - Reset: state=IDLE; every output 0; width_q=2'b00. Reset mid-operation aborts immediately.
//    No done/error is reported for the aborted operation.
//  - All outputs are registered. Pulses last exactly one clk.
//  - IDLE: ctrl_wr with legal mode and legal width -> LATCH. width_q<=codeword_width[1:0]; op_error<=0.
//  - IDLE: ctrl_wr with mode 11 or width 11 -> stay IDLE; op_error<=1 next cycle; op_done pulses.
//  - ctrl_wr while busy: ignored. No state change, no error, latched width unchanged.
//  - LATCH (1 cycle, latch_en=1) -> ENC for modes 00/10, or -> DEC for mode 01.
//  - ENC: enc_start=1 on the first ENC cycle only. enc_done is sampled every ENC cycle,
//    including the first. On enc_done: mode 00 -> DONE; mode 10 -> NOISE.
//  - NOISE (1 cycle, noise_en=1) -> DEC.
//  - DEC: dec_start=1 on the first DEC cycle only. On dec_done -> DONE.
//  - DONE (1 cycle): op_done=1 -> IDLE. A ctrl_wr in DONE is ignored.
//  - enc_done or dec_done arriving outside its own state is ignored.
//  - Latency, IDLE write to op_done:
//    - enc or dec mode: 3 + N cycles, N = cycles from the start pulse to done (N>=0).
//    - full channel: 5 + Nenc + Ndec cycles.
// CONFIGURATION
//  ENC_DEC_WATCHDOG_EN defined:
//  - A stage counter clears on entry to ENC or DEC and increments each cycle in that state.
//  - Counter reaching TIMEOUT_CYCLES-1 with no done -> DONE with op_error=1. op_done still pulses.
//  - A done arriving on the timeout cycle wins: no error.
//  ENC_DEC_WATCHDOG_EN undefined:
//  - No counter. ENC/DEC wait indefinitely. op_error is set only by illegal configuration.
// STRUCTURE
//  - enc_dec_pkg holds the shared definitions:
//    - MODE_ENC/MODE_DEC/MODE_FULL/MODE_ILL 2-bit encodings
//    - WIDTH_8/16/32 encodings
//    - state encoding IDLE, LATCH, ENC, NOISE, DEC, DONE (3 bits)
//    - TIMEOUT default
//  - One sub-module: enc_dec_stage_watchdog. It takes clear, enable and TIMEOUT_CYCLES
//    and outputs expired. It is instantiated only under ENC_DEC_WATCHDOG_EN.
// TESTING
//  1. Reset check: assert rst mid-ENC -> all outputs 0 same cycle; state IDLE;
//     no op_done after release.
//  2. Encode: ctrl=0, width=2'b01, ctrl_wr; enc_done 2 cycles after enc_start ->
//     - latch_en, then enc_start, then op_done 5 cycles after ctrl_wr
//     - width_q=01, op_error=0
//  3. Full channel: ctrl=2, enc_done=1 held, dec_done=1 held ->
//     pulse order latch_en, enc_start, noise_en, dec_start, op_done on consecutive cycles.
//  4. Illegal config: ctrl=3 -> op_error=1, op_done pulse, busy stays 0.
//     A following legal ctrl_wr clears op_error.
//  5. Busy collision: second ctrl_wr (mode 01) during ENC of mode 00 ->
//     ignored; operation completes as encode only.
//  6. Watchdog (macro on, TIMEOUT=64): dec_done never asserts ->
//     op_done + op_error 64 cycles after dec_start.

Source files
------------

// File: rtl/enc_dec_pkg.sv
// Shared definitions for the encoder/decoder operation sequencer: mode and width
// encodings, FSM state encoding and the default stage timeout.
package enc_dec_pkg;

  localparam logic [1:0] MODE_ENC  = 2'b00;
  localparam logic [1:0] MODE_DEC  = 2'b01;
  localparam logic [1:0] MODE_FULL = 2'b10;
  localparam logic [1:0] MODE_ILL  = 2'b11;

  localparam logic [1:0] WIDTH_8   = 2'b00;
  localparam logic [1:0] WIDTH_16  = 2'b01;
  localparam logic [1:0] WIDTH_32  = 2'b10;
  localparam logic [1:0] WIDTH_ILL = 2'b11;

  localparam int TIMEOUT_DEFAULT = 64;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LATCH = 3'd1,
    ENC   = 3'd2,
    NOISE = 3'd3,
    DEC   = 3'd4,
    DONE  = 3'd5
  } state_t;

  function automatic logic cfg_legal(input logic [1:0] mode, input logic [1:0] width);
    return (mode != MODE_ILL) && (width != WIDTH_ILL);
  endfunction

endpackage

// File: rtl/enc_dec_stage_watchdog.sv
// Per-stage cycle counter: clears on stage entry, counts while enabled and flags
// expiry on the cycle the count reaches TIMEOUT_CYCLES-1.
module enc_dec_stage_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = enable && (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/enc_dec_op_sequencer.sv
// Sequences one enc/noise/dec operation after a CTRL write. Optional per-stage
// watchdog is built when ENC_DEC_WATCHDOG_EN is defined.
module enc_dec_op_sequencer
  import enc_dec_pkg::*;
#(
  parameter int AMBA_WORD      = 32,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ctrl_wr,
  input  logic [AMBA_WORD-1:0] ctrl,
  input  logic [AMBA_WORD-1:0] codeword_width,
  input  logic                 enc_done,
  input  logic                 dec_done,
  output logic                 latch_en,
  output logic [1:0]           width_q,
  output logic                 enc_start,
  output logic                 noise_en,
  output logic                 dec_start,
  output logic                 busy,
  output logic                 op_done,
  output logic                 op_error
);

  state_t     state_q, state_d;
  logic [1:0] mode_q, mode_d;
  logic [1:0] width_d;
  logic       err_d;
  logic       ill_done_d;
  logic       expired;
  logic       stage_entry;

  logic unused_bits;
  assign unused_bits = ^{ctrl[AMBA_WORD-1:2], codeword_width[AMBA_WORD-1:2]};

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    width_d    = width_q;
    err_d      = op_error;
    ill_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ctrl_wr) begin
          if (cfg_legal(ctrl[1:0], codeword_width[1:0])) begin
            state_d = LATCH;
            mode_d  = ctrl[1:0];
            width_d = codeword_width[1:0];
            err_d   = 1'b0;
          end else begin
            err_d      = 1'b1;
            ill_done_d = 1'b1;
          end
        end
      end
      LATCH: state_d = (mode_q == MODE_DEC) ? DEC : ENC;
      ENC: begin
        if (enc_done) begin
          state_d = (mode_q == MODE_FULL) ? NOISE : DONE;
        end else if (expired) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      NOISE: state_d = DEC;
      DEC: begin
        if (dec_done) begin
          state_d = DONE;
        end else if (expired) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage entry pulses double as the watchdog clear.
  assign stage_entry = ((state_d == ENC) && (state_q != ENC)) ||
                       ((state_d == DEC) && (state_q != DEC));

`ifdef ENC_DEC_WATCHDOG_EN
  enc_dec_stage_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (stage_entry),
    .enable ((state_q == ENC) || (state_q == DEC)),
    .expired(expired)
  );
`else
  logic unused_entry;
  assign unused_entry = stage_entry;
  assign expired      = 1'b0;
`endif

  // Outputs are registered from the next-state decode so they align with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= MODE_ENC;
      width_q   <= WIDTH_8;
      latch_en  <= 1'b0;
      enc_start <= 1'b0;
      noise_en  <= 1'b0;
      dec_start <= 1'b0;
      busy      <= 1'b0;
      op_done   <= 1'b0;
      op_error  <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      width_q   <= width_d;
      latch_en  <= (state_d == LATCH);
      enc_start <= (state_d == ENC) && (state_q != ENC);
      noise_en  <= (state_d == NOISE);
      dec_start <= (state_d == DEC) && (state_q != DEC);
      busy      <= (state_d != IDLE);
      op_done   <= (state_d == DONE) || ill_done_d;
      op_error  <= err_d;
    end
  end

endmodule

// File: tb/tb_enc_dec_op_sequencer.sv
// Randomized bench for enc_dec_op_sequencer; expectations come from a per-operation
// timeline model. Watchdog cases run when ENC_DEC_WATCHDOG_EN is defined.
module tb_enc_dec_op_sequencer;
  import enc_dec_pkg::*;

  localparam int TO = TIMEOUT_DEFAULT;
`ifdef ENC_DEC_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ctrl_wr = 1'b0;
  logic [31:0] ctrl = '0;
  logic [31:0] codeword_width = '0;
  logic        enc_done = 1'b0;
  logic        dec_done = 1'b0;
  logic        latch_en, enc_start, noise_en, dec_start, busy, op_done, op_error;
  logic [1:0]  width_q;

  enc_dec_op_sequencer #(.AMBA_WORD(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .ctrl_wr       (ctrl_wr),
    .ctrl          (ctrl),
    .codeword_width(codeword_width),
    .enc_done      (enc_done),
    .dec_done      (dec_done),
    .latch_en      (latch_en),
    .width_q       (width_q),
    .enc_start     (enc_start),
    .noise_en      (noise_en),
    .dec_start     (dec_start),
    .busy          (busy),
    .op_done       (op_done),
    .op_error      (op_error)
  );

  always #5 clk = ~clk;

  // {width_q, op_error, op_done, busy, dec_start, noise_en, enc_start, latch_en}
  logic [8:0] obs;
  assign obs = {width_q, op_error, op_done, busy, dec_start, noise_en, enc_start, latch_en};

  int checks = 0;
  int errors = 0;
  logic [1:0] prev_w = 2'b00;
  logic       prev_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One CTRL write and its whole operation. Entered just after a rising edge.
  // ne/nd: cycles from start pulse to done; collide: hold ctrl_wr high while busy.
  task automatic run_txn(input logic [1:0] m, input logic [1:0] w, input int ne,
                         input int nd, input bit collide, input string tag);
    bit ill, to, in_enc, in_dec;
    int enc_s, enc_e, noise_t, dec_s, dec_e, done_t;
    logic [8:0] exp;
    ill = (m == MODE_ILL) || (w == WIDTH_ILL);
    to = 1'b0;
    enc_s = -1; enc_e = -1; noise_t = -1; dec_s = -1; dec_e = -1; done_t = 1;
    if (!ill) begin
      if (m != MODE_DEC) begin
        enc_s = 2;
        if (WD && ne >= TO) begin to = 1'b1; enc_e = enc_s + TO - 1; end
        else enc_e = enc_s + ne;
        if (m == MODE_ENC || to) done_t = enc_e + 1;
        else begin noise_t = enc_e + 1; dec_s = enc_e + 2; end
      end else begin
        dec_s = 2;
      end
      if (dec_s >= 0) begin
        if (WD && nd >= TO) begin to = 1'b1; dec_e = dec_s + TO - 1; end
        else dec_e = dec_s + nd;
        done_t = dec_e + 1;
      end
    end

    for (int t = 0; t <= done_t + 1; t++) begin
      ctrl           = {$urandom_range(0, 1) ? 30'h0 : 30'($urandom), 2'($urandom)};
      codeword_width = {30'($urandom), 2'($urandom)};
      if (t == 0) begin
        ctrl_wr = 1'b1;
        ctrl[1:0] = m;
        codeword_width[1:0] = w;
      end else begin
        ctrl_wr = collide && !ill && (t <= done_t);
        if (ctrl_wr) ctrl[1:0] = MODE_DEC;
      end
      in_enc = (enc_s >= 0) && (t >= enc_s) && (t <= enc_e);
      in_dec = (dec_s >= 0) && (t >= dec_s) && (t <= dec_e);
      enc_done = in_enc ? (t == enc_s + ne) : 1'($urandom_range(0, 1));
      dec_done = in_dec ? (t == dec_s + nd) : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (t == 0) begin
        exp = {prev_w, prev_err, 6'b0};
      end else begin
        exp[8:7] = ill ? prev_w : w;
        exp[6]   = ill ? 1'b1 : (to && t >= done_t);
        exp[5]   = (t == done_t);
        exp[4]   = !ill && (t <= done_t);
        exp[3]   = (t == dec_s);
        exp[2]   = (t == noise_t);
        exp[1]   = (t == enc_s);
        exp[0]   = !ill && (t == 1);
      end
      check($sformatf("%s t=%0d", tag, t), 32'(obs), 32'(exp));
      @(posedge clk);
      #1;
    end
    ctrl_wr  = 1'b0;
    prev_err = ill || to;
    if (!ill) prev_w = w;
  endtask

  initial begin
    logic [1:0] m, w;
    // Reset state
    repeat (2) @(negedge clk);
    check("reset_state", 32'(obs), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset asserted mid-ENC: outputs clear at once, no op_done afterwards
    ctrl_wr = 1'b1; ctrl = 32'h0; codeword_width = 32'h1; enc_done = 1'b0;
    @(posedge clk); #1;
    ctrl_wr = 1'b0;
    @(posedge clk); #1;                      // LATCH -> ENC edge
    check("enc_start_before_rst", 32'(enc_start), 32'h1);
    #2 rst = 1'b1;
    #1 check("rst_async", 32'(obs), 32'h0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("post_rst c=%0d", i), 32'(obs), 32'h0);
    end
    prev_w = 2'b00; prev_err = 1'b0;
    @(posedge clk); #1;

    // Directed scenarios
    run_txn(MODE_ENC,  WIDTH_16, 2, 0, 1'b0, "encode");
    run_txn(MODE_FULL, WIDTH_32, 0, 0, 1'b0, "full_back2back");
    run_txn(MODE_ILL,  WIDTH_8,  0, 0, 1'b0, "illegal_mode");
    run_txn(MODE_DEC,  WIDTH_8,  1, 1, 1'b0, "legal_clears_err");
    run_txn(MODE_ENC,  WIDTH_ILL, 0, 0, 1'b0, "illegal_width");
    run_txn(MODE_ENC,  WIDTH_8,  3, 0, 1'b1, "busy_collide");
    run_txn(MODE_DEC,  WIDTH_16, 0, 4, 1'b0, "decode");
    if (WD) begin
      run_txn(MODE_DEC,  WIDTH_8,  0, TO + 5, 1'b0, "wd_dec_timeout");
      run_txn(MODE_FULL, WIDTH_16, TO, 0, 1'b0, "wd_enc_timeout");
      run_txn(MODE_ENC,  WIDTH_32, TO - 1, 0, 1'b0, "wd_done_wins");
    end

    // Randomized operations
    for (int k = 0; k < 150; k++) begin
      m = ($urandom_range(0, 7) == 0) ? MODE_ILL : 2'($urandom_range(0, 2));
      w = ($urandom_range(0, 7) == 0) ? WIDTH_ILL : 2'($urandom_range(0, 2));
      run_txn(m, w, $urandom_range(0, 6), $urandom_range(0, 6),
              1'($urandom_range(0, 1)), $sformatf("rnd%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
